// File: rtl/bus_arb_pkg.sv
// Shared constants and helpers for the round-robin bus arbiter.
package bus_arb_pkg;

    localparam int unsigned MinOutstanding = 1;
    localparam int unsigned MaxOutstandingLimit = 8;

    // Width needed to index n entries; never zero so single-entry cases stay legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_arb_id_fifo.sv
// In-order FIFO of host indices for transactions awaiting a downstream response.
module bus_arb_id_fifo
    import bus_arb_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [Width-1:0] head
);

    localparam int unsigned PtrW = idx_width(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; an entry is only read after it has been written, and the empty count guards stale data.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter funnelling several hosts onto one pipelined bus with in-order responses.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NrHosts-1:0]                      host_req_i,
    output logic [NrHosts-1:0]                      host_gnt_o,
    input  logic [NrHosts-1:0][AddressWidth-1:0]    host_addr_i,
    input  logic [NrHosts-1:0]                      host_we_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]     host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]       host_wdata_i,
    output logic [NrHosts-1:0]                      host_rvalid_o,
    output logic [NrHosts-1:0][DataWidth-1:0]       host_rdata_o,
    output logic [NrHosts-1:0]                      host_err_o,
    output logic                                    dev_req_o,
    output logic [AddressWidth-1:0]                 dev_addr_o,
    output logic                                    dev_we_o,
    output logic [DataWidth/8-1:0]                  dev_be_o,
    output logic [DataWidth-1:0]                    dev_wdata_o,
    input  logic                                    dev_gnt_i,
    input  logic                                    dev_rvalid_i,
    input  logic [DataWidth-1:0]                    dev_rdata_i,
    input  logic                                    dev_err_i,
    output logic                                    orphan_rsp_o
);

    localparam int unsigned HostIdxW = idx_width(NrHosts);

    if (MaxOutstanding < MinOutstanding || MaxOutstanding > MaxOutstandingLimit) begin : g_bad_depth
        $error("MaxOutstanding out of range");
    end

    logic [HostIdxW-1:0] prio_ptr;
    logic [HostIdxW-1:0] winner;
    logic [HostIdxW-1:0] head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                accept;
    logic                rsp_valid;

    // Search upward from the priority pointer; with no request the pointer's host drives the payload.
    always_comb begin
        logic found;
        found  = 1'b0;
        winner = prio_ptr;
        for (int unsigned i = 0; i < NrHosts; i++) begin
            int unsigned idx;
            idx = (32'(prio_ptr) + i) % NrHosts;
            if (!found && host_req_i[idx]) begin
                found  = 1'b1;
                winner = HostIdxW'(idx);
            end
        end
    end

    assign dev_req_o   = ~rst_i & (|host_req_i) & ~fifo_full;
    assign accept      = dev_req_o & dev_gnt_i;
    assign dev_addr_o  = host_addr_i[winner];
    assign dev_we_o    = host_we_i[winner];
    assign dev_be_o    = host_be_i[winner];
    assign dev_wdata_o = host_wdata_i[winner];

    assign rsp_valid    = ~rst_i & dev_rvalid_i & ~fifo_empty;
    assign orphan_rsp_o = ~rst_i & dev_rvalid_i & fifo_empty;

    always_comb begin
        for (int unsigned h = 0; h < NrHosts; h++) begin
            host_gnt_o[h]    = accept & (winner == HostIdxW'(h));
            host_rvalid_o[h] = rsp_valid & (head == HostIdxW'(h));
            host_err_o[h]    = rsp_valid & (head == HostIdxW'(h)) & dev_err_i;
            host_rdata_o[h]  = dev_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_ptr <= '0;
        end else if (accept) begin
            prio_ptr <= (winner == HostIdxW'(NrHosts - 1)) ? '0 : winner + 1'b1;
        end
    end

    bus_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (HostIdxW)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (accept),
        .push_data (winner),
        .pop       (rsp_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter with two hosts and two outstanding transactions.
module tb_bus_rr_arbiter;

    localparam int unsigned NrHosts = 2;
    localparam int unsigned Dw      = 32;
    localparam int unsigned Aw      = 32;

    logic                         clk_i = 1'b0;
    logic                         rst_i;
    logic [NrHosts-1:0]           host_req_i;
    logic [NrHosts-1:0]           host_gnt_o;
    logic [NrHosts-1:0][Aw-1:0]   host_addr_i;
    logic [NrHosts-1:0]           host_we_i;
    logic [NrHosts-1:0][Dw/8-1:0] host_be_i;
    logic [NrHosts-1:0][Dw-1:0]   host_wdata_i;
    logic [NrHosts-1:0]           host_rvalid_o;
    logic [NrHosts-1:0][Dw-1:0]   host_rdata_o;
    logic [NrHosts-1:0]           host_err_o;
    logic                         dev_req_o;
    logic [Aw-1:0]                dev_addr_o;
    logic                         dev_we_o;
    logic [Dw/8-1:0]              dev_be_o;
    logic [Dw-1:0]                dev_wdata_o;
    logic                         dev_gnt_i;
    logic                         dev_rvalid_i;
    logic [Dw-1:0]                dev_rdata_i;
    logic                         dev_err_i;
    logic                         orphan_rsp_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    bus_rr_arbiter #(
        .NrHosts        (NrHosts),
        .DataWidth      (Dw),
        .AddressWidth   (Aw),
        .MaxOutstanding (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .host_req_i    (host_req_i),
        .host_gnt_o    (host_gnt_o),
        .host_addr_i   (host_addr_i),
        .host_we_i     (host_we_i),
        .host_be_i     (host_be_i),
        .host_wdata_i  (host_wdata_i),
        .host_rvalid_o (host_rvalid_o),
        .host_rdata_o  (host_rdata_o),
        .host_err_o    (host_err_o),
        .dev_req_o     (dev_req_o),
        .dev_addr_o    (dev_addr_o),
        .dev_we_o      (dev_we_o),
        .dev_be_o      (dev_be_o),
        .dev_wdata_o   (dev_wdata_o),
        .dev_gnt_i     (dev_gnt_i),
        .dev_rvalid_i  (dev_rvalid_i),
        .dev_rdata_i   (dev_rdata_i),
        .dev_err_i     (dev_err_i),
        .orphan_rsp_o  (orphan_rsp_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled at the falling edge.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    // Expected grant / rvalid per cycle for two continuous requesters, rvalid one cycle behind.
    logic [1:0] exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] exp_rv  [4] = '{2'b00, 2'b01, 2'b10, 2'b01};

    initial begin
        host_addr_i  = '{32'h0000_2000, 32'h0000_1000};
        host_wdata_i = '{32'h2222_2222, 32'h1111_1111};
        host_we_i    = 2'b01;
        host_be_i    = '{4'h3, 4'hF};
        rst_i        = 1'b1;
        host_req_i   = 2'b11;
        dev_gnt_i    = 1'b1;
        dev_rvalid_i = 1'b1;
        dev_rdata_i  = 32'h0;
        dev_err_i    = 1'b1;
        #1;

        // Outputs held low while in reset even with live requests and responses.
        sample();
        check("rst_dev_req", dev_req_o, 0);
        check("rst_gnt", host_gnt_o, 0);
        check("rst_rvalid", host_rvalid_o, 0);
        check("rst_err", host_err_o, 0);
        check("rst_orphan", orphan_rsp_o, 0);
        next_cycle();
        next_cycle();

        // Response with nothing outstanding is an orphan.
        rst_i      = 1'b0;
        host_req_i = 2'b00;
        dev_err_i  = 1'b0;
        sample();
        check("orphan_pulse", orphan_rsp_o, 1);
        check("orphan_rvalid", host_rvalid_o, 0);
        next_cycle();
        dev_rvalid_i = 1'b0;
        sample();
        check("orphan_clear", orphan_rsp_o, 0);
        next_cycle();

        // Alternating grants with responses returning to the issuing host.
        host_req_i = 2'b11;
        for (int c = 0; c < 4; c++) begin
            dev_rvalid_i = (c != 0);
            dev_rdata_i  = 32'hA0 + 32'(c);
            sample();
            check($sformatf("rr_gnt_%0d", c), host_gnt_o, exp_gnt[c]);
            check($sformatf("rr_rvalid_%0d", c), host_rvalid_o, exp_rv[c]);
            check($sformatf("rr_addr_%0d", c), dev_addr_o, (c % 2 == 0) ? 32'h1000 : 32'h2000);
            next_cycle();
        end

        // Last outstanding read belongs to host 1: error response with broadcast data.
        host_req_i   = 2'b00;
        dev_rvalid_i = 1'b1;
        dev_rdata_i  = 32'hDEAD_BEEF;
        dev_err_i    = 1'b1;
        sample();
        check("err_rvalid", host_rvalid_o, 2'b10);
        check("err_rdata1", host_rdata_o[1], 32'hDEAD_BEEF);
        check("err_rdata0_bcast", host_rdata_o[0], 32'hDEAD_BEEF);
        check("err_err", host_err_o, 2'b10);
        check("err_no_orphan", orphan_rsp_o, 0);
        next_cycle();

        // Outstanding limit: two grants, then stall until a response frees a slot.
        dev_rvalid_i = 1'b0;
        dev_err_i    = 1'b0;
        host_req_i   = 2'b11;
        sample();
        check("lim_gnt_a", host_gnt_o, 2'b01);
        next_cycle();
        sample();
        check("lim_gnt_b", host_gnt_o, 2'b10);
        check("lim_payload_b", {dev_we_o, dev_be_o, dev_wdata_o}, {1'b0, 4'h3, 32'h2222_2222});
        next_cycle();
        for (int c = 0; c < 2; c++) begin
            sample();
            check($sformatf("lim_stall_req_%0d", c), dev_req_o, 0);
            check($sformatf("lim_stall_gnt_%0d", c), host_gnt_o, 0);
            next_cycle();
        end
        dev_rvalid_i = 1'b1;
        sample();
        check("lim_pop_rvalid", host_rvalid_o, 2'b01);
        check("lim_pop_no_req", dev_req_o, 0);
        check("lim_pop_no_gnt", host_gnt_o, 0);
        next_cycle();
        dev_rvalid_i = 1'b0;
        sample();
        check("lim_resume_gnt", host_gnt_o, 2'b01);
        check("lim_resume_payload", {dev_we_o, dev_be_o, dev_wdata_o}, {1'b1, 4'hF, 32'h1111_1111});
        next_cycle();

        // Reset with two outstanding: both later responses become orphans, pointer back at 0.
        host_req_i = 2'b00;
        rst_i      = 1'b1;
        next_cycle();
        rst_i        = 1'b0;
        dev_rvalid_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            sample();
            check($sformatf("mid_rst_orphan_%0d", c), orphan_rsp_o, 1);
            check($sformatf("mid_rst_rvalid_%0d", c), host_rvalid_o, 0);
            next_cycle();
        end
        dev_rvalid_i = 1'b0;
        host_req_i   = 2'b11;
        sample();
        check("post_rst_gnt", host_gnt_o, 2'b01);
        next_cycle();

        // Downstream stall: no grants, pointer holds at host 1, payload stays host 1's.
        dev_gnt_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sample();
            check($sformatf("stall_gnt_%0d", c), host_gnt_o, 0);
            check($sformatf("stall_req_%0d", c), dev_req_o, 1);
            check($sformatf("stall_addr_%0d", c), dev_addr_o, 32'h2000);
            next_cycle();
        end
        dev_gnt_i = 1'b1;
        sample();
        check("stall_release_gnt", host_gnt_o, 2'b10);
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
